// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: MIPS ID-stage decoder. It carries the control bundle
// through the ID/EX, EX/MEM and MEM/WB registers, inserts bubbles on stall or
// flush, and flags illegal instructions.
// Optional feature macro: MD_UNIT_EN enables multi-cycle MULT/DIV busy
// tracking and the MFHI/MFLO interlock. When the macro is undefined, those
// opcodes decode as illegal.
module pipelined_control_unit #(
    parameter int ALU_OP_W   = 4,
    parameter int NPC_OP_W   = 2,
    parameter int MD_LATENCY = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [5:0]          i_opcode,
    input  logic [5:0]          i_func,
    input  logic                i_isRsRtEq,
    input  logic                i_stallD,
    input  logic                i_flushE,
    output logic [NPC_OP_W-1:0] o_npcOpD,
    output logic [ALU_OP_W-1:0] o_aluOpE,
    output logic                o_aluSrc2E,
    output logic                o_regDstE,
    output logic                o_regWeE,
    output logic                o_regWeM,
    output logic                o_regWeW,
    output logic                o_memToRegE,
    output logic                o_memToRegM,
    output logic                o_memToRegW,
    output logic                o_memWeM,
    output logic                o_illegalE,
    output logic                o_mdBusy,
    output logic                o_stallReq
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Control bundle carried into EX. md marks a MULT/DIV that occupies the unit.
    typedef struct packed {
        logic [ALU_OP_W-1:0] aluOp;
        logic                aluSrc2;
        logic                regDst;
        logic                regWe;
        logic                memToReg;
        logic                memWe;
        logic                illegal;
        logic                md;
    } ctrl_t;

    ctrl_t w_dec;
    ctrl_t r_E;
    logic  w_isMdOp;    // ID holds MULT/DIV
    logic  w_isMf;      // ID holds MFHI/MFLO
    logic  w_bubbleE;
    logic  r_regWeM, r_memToRegM, r_memWeM;
    logic  r_regWeW, r_memToRegW;

    // ID decode: control bundle plus the combinational next-PC select.
    always_comb begin
        w_dec    = '0;
        o_npcOpD = '0;
        w_isMdOp = 1'b0;
        w_isMf   = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                w_dec.regWe  = 1'b1;
                w_dec.regDst = 1'b1;
                case (i_func)
                    6'b100000: w_dec.aluOp = ALU_ADD;
                    6'b100010: w_dec.aluOp = ALU_SUB;
                    6'b100100: w_dec.aluOp = ALU_AND;
                    6'b100101: w_dec.aluOp = ALU_OR;
                    6'b101010: w_dec.aluOp = ALU_SLT;
`ifdef MD_UNIT_EN
                    // MULT/DIV write HI/LO inside the unit, so there is no regfile write.
                    6'b011000, 6'b011010: begin
                        w_dec.regWe  = 1'b0;
                        w_dec.regDst = 1'b0;
                        w_dec.md     = 1'b1;
                        w_isMdOp     = 1'b1;
                    end
                    6'b010000, 6'b010010: w_isMf = 1'b1;
`endif
                    default: begin
                        w_dec.regWe   = 1'b0;
                        w_dec.regDst  = 1'b0;
                        w_dec.illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                w_dec.aluSrc2 = 1'b1;
                w_dec.regWe   = 1'b1;
            end
            OP_LW: begin
                w_dec.aluSrc2  = 1'b1;
                w_dec.regWe    = 1'b1;
                w_dec.memToReg = 1'b1;
            end
            OP_SW: begin
                w_dec.aluSrc2 = 1'b1;
                w_dec.memWe   = 1'b1;
            end
            OP_BEQ:  o_npcOpD = i_isRsRtEq ? NPC_OP_W'(1) : NPC_OP_W'(0);
            OP_J:    o_npcOpD = NPC_OP_W'(2);
            default: w_dec.illegal = 1'b1;
        endcase
    end

    // A stall request from the MD interlock has the same effect as the hazard unit's stall.
    assign w_bubbleE = i_stallD | i_flushE | o_stallReq;

    // ID/EX register: a bubble is an all-zero bundle.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_bubbleE) r_E <= '0;
        else                    r_E <= w_dec;
    end

    // EX/MEM and MEM/WB always advance, even while ID is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regWeM    <= 1'b0;
            r_memToRegM <= 1'b0;
            r_memWeM    <= 1'b0;
            r_regWeW    <= 1'b0;
            r_memToRegW <= 1'b0;
        end else begin
            r_regWeM    <= r_E.regWe;
            r_memToRegM <= r_E.memToReg;
            r_memWeM    <= r_E.memWe;
            r_regWeW    <= r_regWeM;
            r_memToRegW <= r_memToRegM;
        end
    end

`ifdef MD_UNIT_EN
    localparam int CNT_W = $clog2(MD_LATENCY);

    logic             r_mdBusy;
    logic [CNT_W-1:0] r_mdCnt;
    logic             w_mdStart;

    // The unit starts only when a MULT/DIV actually enters EX.
    assign w_mdStart = w_dec.md & ~w_bubbleE;

    // Occupancy counter. Busy lasts MD_LATENCY cycles, including the cycle where the count is 0.
    // A start on the expiry cycle takes priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mdBusy <= 1'b0;
            r_mdCnt  <= '0;
        end else if (w_mdStart) begin
            r_mdBusy <= 1'b1;
            r_mdCnt  <= CNT_W'(MD_LATENCY - 1);
        end else if (r_mdBusy) begin
            if (r_mdCnt == '0) r_mdBusy <= 1'b0;
            else               r_mdCnt  <= r_mdCnt - 1'b1;
        end
    end

    assign o_mdBusy   = r_mdBusy;
    assign o_stallReq = ((w_isMdOp | w_isMf) & r_mdBusy) | (w_isMf & r_E.md);

    logic w_unused_md;
    assign w_unused_md = r_E.md;
`else
    assign o_mdBusy   = 1'b0;
    assign o_stallReq = 1'b0;

    // Without the unit, these signals stay constant at 0.
    logic w_unused_md;
    assign w_unused_md = r_E.md ^ w_isMdOp ^ w_isMf ^ MD_LATENCY[0];
`endif

    assign o_aluOpE    = r_E.aluOp;
    assign o_aluSrc2E  = r_E.aluSrc2;
    assign o_regDstE   = r_E.regDst;
    assign o_regWeE    = r_E.regWe;
    assign o_memToRegE = r_E.memToReg;
    assign o_illegalE  = r_E.illegal;
    assign o_regWeM    = r_regWeM;
    assign o_memToRegM = r_memToRegM;
    assign o_memWeM    = r_memWeM;
    assign o_regWeW    = r_regWeW;
    assign o_memToRegW = r_memToRegW;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit. Inputs change 1 time unit after
// each rising edge. Registered outputs are sampled at the same point.
// Combinational outputs are sampled 1 time unit after the inputs change.
module tb_pipelined_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, func;
    logic       isRsRtEq, stallD, flushE;
    logic [1:0] npcOpD;
    logic [3:0] aluOpE;
    logic       aluSrc2E, regDstE, regWeE, regWeM, regWeW;
    logic       memToRegE, memToRegM, memToRegW, memWeM, illegalE, mdBusy, stallReq;

    int n_chk  = 0;
    int n_pass = 0;

    pipelined_control_unit #(.ALU_OP_W(4), .NPC_OP_W(2), .MD_LATENCY(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_func(func),
        .i_isRsRtEq(isRsRtEq), .i_stallD(stallD), .i_flushE(flushE),
        .o_npcOpD(npcOpD), .o_aluOpE(aluOpE), .o_aluSrc2E(aluSrc2E),
        .o_regDstE(regDstE), .o_regWeE(regWeE), .o_regWeM(regWeM),
        .o_regWeW(regWeW), .o_memToRegE(memToRegE), .o_memToRegM(memToRegM),
        .o_memToRegW(memToRegW), .o_memWeM(memWeM), .o_illegalE(illegalE),
        .o_mdBusy(mdBusy), .o_stallReq(stallReq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        func   = fn;
    endtask

    initial begin
        rst = 1'b1; isRsRtEq = 1'b0; stallD = 1'b0; flushE = 1'b0;
        ins(OP_LW, 6'd0);
        step(); step();
        // Reset holds every stage at zero even with LW in ID.
        chk("rst_regWeE",    regWeE,    0);
        chk("rst_memToRegE", memToRegE, 0);
        chk("rst_aluSrc2E",  aluSrc2E,  0);
        chk("rst_illegalE",  illegalE,  0);
        chk("rst_MW", {regWeM, memToRegM, memWeM, regWeW, memToRegW}, 0);
        chk("rst_mdBusy",    mdBusy,    0);

        // LW marches E -> M -> W.
        rst = 1'b0;
        step();
        ins(OP_BEQ, 6'd0);
        chk("lw_E", {regWeE, memToRegE, aluSrc2E, regDstE, illegalE}, 5'b11100);
        chk("lw_aluOpE", aluOpE, 0);
        step();
        chk("lw_M", {regWeM, memToRegM, regWeE}, 3'b110);
        step();
        chk("lw_W", {regWeW, memToRegW, regWeM}, 3'b110);

        // Next-PC select is combinational.
        ins(OP_BEQ, 6'd0); isRsRtEq = 1'b1; #1;
        chk("beq_taken", npcOpD, 1);
        isRsRtEq = 1'b0; #1;
        chk("beq_not", npcOpD, 0);
        ins(OP_J, 6'd0); #1;
        chk("j_npc", npcOpD, 2);
        ins(OP_R, F_ADD); isRsRtEq = 1'b1; #1;
        chk("add_npc", npcOpD, 0);
        ins(OP_BEQ, 6'd0);
        step();
        ins(OP_SW, 6'd0);
        chk("beq_E", {regWeE, illegalE, memToRegE}, 0);

        // SW without flush writes memory in MEM.
        step();
        ins(OP_SW, 6'd0); flushE = 1'b1;
        chk("sw_E", {aluSrc2E, regWeE, regDstE}, 3'b100);
        chk("beq_memWeM", memWeM, 0);
        step();
        flushE = 1'b0; ins(OP_BEQ, 6'd0);
        chk("sw_memWeM", memWeM, 1);
        chk("flush_E", {aluSrc2E, regWeE, memToRegE, illegalE}, 0);
        step();
        chk("flush_memWeM", memWeM, 0);

        // A stall bubbles EX while an older LW drains through M/W.
        ins(OP_LW, 6'd0);
        step();
        ins(OP_R, F_ADD); stallD = 1'b1;
        step();
        stallD = 1'b0;
        chk("stall_E", {regWeE, regDstE}, 0);
        chk("stall_M", {regWeM, memToRegM}, 2'b11);
        step();
        chk("stall_W", {regWeW, memToRegW}, 2'b11);
        chk("unstall_E", {regWeE, regDstE, aluOpE}, 6'b110000);

        // Illegal opcode, then ADD clears it.
        ins(OP_BAD, 6'd0);
        step();
        ins(OP_R, F_ADD);
        chk("ill_E", {illegalE, regWeE, memToRegE, aluSrc2E}, 4'b1000);
        step();
        ins(OP_BEQ, 6'd0);
        chk("ill_memWeM", memWeM, 0);
        chk("add_E", {illegalE, regWeE, regDstE}, 3'b011);
        chk("add_aluOpE", aluOpE, 0);

        // ALU op encoding for the remaining R-type funcs, then an unknown func.
        begin
            logic [5:0] fns [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
            for (int i = 0; i < 4; i++) begin
                ins(OP_R, fns[i]);
                step();
                chk($sformatf("alu_op%0d", i + 1), {aluOpE, regWeE, illegalE}, {4'(i + 1), 2'b10});
            end
        end
        ins(OP_R, 6'b000001);
        step();
        chk("badfunc_E", {illegalE, regWeE}, 2'b10);
        ins(OP_ADDI, 6'd0);
        step();
        chk("addi_E", {aluSrc2E, regWeE, regDstE, memToRegE, aluOpE}, 8'b11000000);

`ifdef MD_UNIT_EN
        // MULT then MFLO: MFLO waits out the 4-cycle occupancy.
        ins(OP_R, F_MULT);
        #1;
        chk("mult_nostall", stallReq, 0);
        step();
        ins(OP_R, F_MFLO);
        chk("mult_E", {regWeE, illegalE}, 0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("md_stall%0d", c), {stallReq, mdBusy, regWeE}, 3'b110);
            step();
        end
        chk("md_release", {stallReq, mdBusy}, 0);
        step();
        ins(OP_BEQ, 6'd0);
        chk("mflo_E", {regWeE, regDstE, illegalE}, 3'b110);

        // Reset in the middle of a busy window abandons the operation.
        ins(OP_R, F_MULT);
        step();
        ins(OP_R, F_MFLO);
        step();
        chk("md_busy_mid", mdBusy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0; #1;
        chk("md_rst_busy", mdBusy, 0);
        chk("md_rst_stall", stallReq, 0);
`else
        // Without the MD unit, MULT and MFLO are illegal and never stall.
        ins(OP_R, F_MULT);
        #1;
        chk("mult_nostall", stallReq, 0);
        step();
        ins(OP_R, F_MFLO);
        #1;
        chk("mult_ill", {illegalE, regWeE, mdBusy}, 3'b100);
        chk("mflo_nostall", stallReq, 0);
        step();
        chk("mflo_ill", {illegalE, regWeE, regDstE, mdBusy}, 4'b1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
